// File: rtl/ps2_pkg.sv
// PS/2 receiver shared constants: FSM state encodings, prefix codes, frame geometry.
// Latency: n/a (definitions only).
// Backpressure: n/a; the receiver produces strobes and has no ready input.
`timescale 1ns/1ps
package ps2_pkg;

  localparam int DATA_BITS = 8;

  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  // Odd parity across the data byte and its parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] dat, input logic par);
    return ^{dat, par};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizes both PS/2 lines and glitch-filters the clock into a falling-edge strobe.
// Latency: 2 sync flops + FILTER_LEN stable samples from a raw clock edge to clk_fall.
// Backpressure: none; clk_fall is a single-cycle strobe that is never held.
`timescale 1ns/1ps
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk_raw,
  input  logic ps2_dat_raw,
  output logic clk_fall,
  output logic dat_sync
);

  localparam int CW = $clog2(FILTER_LEN) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [1:0]    clk_sync;
  logic [1:0]    dat_ff;
  logic          clk_lvl;
  logic [CW-1:0] flt_cnt;
  logic          flip;

  // Two-flop synchronizers; both lines idle high on the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync <= 2'b11;
      dat_ff   <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk_raw};
      dat_ff   <= {dat_ff[0], ps2_dat_raw};
    end
  end

  // This is the FILTER_LEN-th consecutive sample disagreeing with the filtered level.
  assign flip = (clk_sync[1] != clk_lvl) && (flt_cnt == CNT_LAST);

  // Filtered level only moves after a full run of identical differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_lvl <= 1'b1;
      flt_cnt <= '0;
    end else if (clk_sync[1] == clk_lvl) begin
      flt_cnt <= '0;
    end else if (flip) begin
      clk_lvl <= clk_sync[1];
      flt_cnt <= '0;
    end else begin
      flt_cnt <= flt_cnt + 1'b1;
    end
  end

  // Strobe in the cycle the filtered level commits 1 -> 0, alongside current data.
  assign clk_fall = flip & clk_lvl;
  assign dat_sync = dat_ff[1];

endmodule

// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame receiver: scan codes with break/extended prefix flags folded in.
// Latency: Scan_Valid one CLK after the cycle the stop-bit falling edge is seen.
// Backpressure: none; Scan_Valid/Frame_Error are one-cycle strobes. Macro PS2_PARITY_CHECK_EN enables odd-parity check.
`timescale 1ns/1ps
module ps2_frame_receiver #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       PS2_Clock,
  input  logic       PS2_Data,
  output logic [7:0] Scan_Code,
  output logic       Scan_Valid,
  output logic       Break,
  output logic       Extended,
  output logic       Frame_Error
);
  import ps2_pkg::*;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic          fall;
  logic          dat;
  logic [1:0]    state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_q;
  logic          par_q;
  logic [TW-1:0] tmo_cnt;
  logic          brk_flg;
  logic          ext_flg;
  logic          par_ok;
  logic          stop_hit;
  logic          frame_ok;
  logic          frame_bad;
  logic          tmo_hit;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk         (CLK),
    .rst_n       (RESET),
    .ps2_clk_raw (PS2_Clock),
    .ps2_dat_raw (PS2_Data),
    .clk_fall    (fall),
    .dat_sync    (dat)
  );

`ifdef PS2_PARITY_CHECK_EN
  assign par_ok = odd_parity_ok(shift_q, par_q);
`else
  // Parity is still captured so the frame shape is unchanged; it never vetoes a frame.
  assign par_ok = par_q | 1'b1;
`endif

  assign stop_hit  = (state == ST_STOP) && fall;
  assign frame_ok  = stop_hit && dat && par_ok;
  assign frame_bad = stop_hit && !frame_ok;
  // A falling edge in the terminal cycle rescues the frame.
  assign tmo_hit   = (state != ST_IDLE) && !fall && (tmo_cnt == TMO_LAST);

  // Frame FSM, bit shifter and inter-edge timeout counter.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      if (state == ST_IDLE || fall || tmo_hit) tmo_cnt <= '0;
      else                                     tmo_cnt <= tmo_cnt + 1'b1;

      if (tmo_hit) begin
        state <= ST_IDLE;
      end else if (fall) begin
        case (state)
          ST_IDLE: begin
            if (!dat) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end
          end
          ST_DATA: begin
            shift_q[bit_cnt] <= dat;
            bit_cnt          <= bit_cnt + 1'b1;
            if (bit_cnt == 3'(DATA_BITS - 1)) state <= ST_PARITY;
          end
          ST_PARITY: begin
            par_q <= dat;
            state <= ST_STOP;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Prefix absorption and registered code/strobe outputs.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      Scan_Code   <= '0;
      Scan_Valid  <= 1'b0;
      Break       <= 1'b0;
      Extended    <= 1'b0;
      Frame_Error <= 1'b0;
      brk_flg     <= 1'b0;
      ext_flg     <= 1'b0;
    end else begin
      Scan_Valid  <= 1'b0;
      Frame_Error <= frame_bad | tmo_hit;
      if (tmo_hit) begin
        brk_flg <= 1'b0;
        ext_flg <= 1'b0;
      end else if (frame_ok) begin
        if (shift_q == BREAK_CODE) begin
          brk_flg <= 1'b1;
        end else if (shift_q == EXT_CODE) begin
          ext_flg <= 1'b1;
        end else begin
          Scan_Code  <= shift_q;
          Break      <= brk_flg;
          Extended   <= ext_flg;
          Scan_Valid <= 1'b1;
          brk_flg    <= 1'b0;
          ext_flg    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Directed bench for ps2_frame_receiver: frame table plus timeout, glitch and reset sequences.
// Latency: checks are taken after each frame has fully settled.
// Backpressure: n/a; strobes are counted by a monitor on the falling CLK edge.
`timescale 1ns/1ps
module tb_ps2_frame_receiver;

  // PS/2 half-period shortened from the real 30-50 us so the run stays short;
  // it remains far above the filter and synchronizer delay.
  localparam int HALF = 1000;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       PS2_Clock = 1'b1;
  logic       PS2_Data = 1'b1;
  logic [7:0] Scan_Code;
  logic       Scan_Valid;
  logic       Break;
  logic       Extended;
  logic       Frame_Error;

  int tests = 0;
  int fails = 0;
  int vld_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  logic [7:0] pulse_code;
  logic       pulse_brk;
  logic       pulse_ext;

  ps2_frame_receiver dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .PS2_Clock   (PS2_Clock),
    .PS2_Data    (PS2_Data),
    .Scan_Code   (Scan_Code),
    .Scan_Valid  (Scan_Valid),
    .Break       (Break),
    .Extended    (Extended),
    .Frame_Error (Frame_Error)
  );

  always #5 CLK = ~CLK;

  // Strobe monitor, sampled away from the active edge.
  always @(negedge CLK) begin
    if (Scan_Valid) begin
      vld_cnt    = vld_cnt + 1;
      pulse_code = Scan_Code;
      pulse_brk  = Break;
      pulse_ext  = Extended;
    end
    if (Frame_Error) err_cnt = err_cnt + 1;
    if (Scan_Valid && Frame_Error) both_cnt = both_cnt + 1;
  end

  typedef struct {
    logic [7:0] dat;
    logic       par_bad;
    logic       stop;
    int         exp_vld;
    int         exp_err;
    logic [7:0] exp_code;
    logic       exp_brk;
    logic       exp_ext;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic ps2_bit(input logic b);
    PS2_Data = b;
    #HALF;
    PS2_Clock = 1'b0;
    #HALF;
    PS2_Clock = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_bad, input logic stop);
    logic par;
    par = (~^d) ^ par_bad;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(par);
    ps2_bit(stop);
    PS2_Data = 1'b1;
    #(2 * HALF);
  endtask

  initial begin
    int v0, e0;

    //                dat    pbad  stop vld err code   brk   ext
    vecs[0]  = '{8'h78, 1'b0, 1'b1, 1, 0, 8'h78, 1'b0, 1'b0};
    vecs[1]  = '{8'h05, 1'b0, 1'b1, 1, 0, 8'h05, 1'b0, 1'b0};
    vecs[2]  = '{8'hF0, 1'b0, 1'b1, 0, 0, 8'h05, 1'b0, 1'b0};
    vecs[3]  = '{8'h05, 1'b0, 1'b1, 1, 0, 8'h05, 1'b1, 1'b0};
    vecs[4]  = '{8'hE0, 1'b0, 1'b1, 0, 0, 8'h05, 1'b1, 1'b0};
    vecs[5]  = '{8'hF0, 1'b0, 1'b1, 0, 0, 8'h05, 1'b1, 1'b0};
    vecs[6]  = '{8'h75, 1'b0, 1'b1, 1, 0, 8'h75, 1'b1, 1'b1};
    vecs[7]  = '{8'h16, 1'b0, 1'b1, 1, 0, 8'h16, 1'b0, 1'b0};
    vecs[8]  = '{8'h1E, 1'b0, 1'b0, 0, 1, 8'h16, 1'b0, 1'b0};
    vecs[9]  = '{8'hF0, 1'b0, 1'b1, 0, 0, 8'h16, 1'b0, 1'b0};
    vecs[10] = '{8'hF0, 1'b0, 1'b1, 0, 0, 8'h16, 1'b0, 1'b0};
    vecs[11] = '{8'h1C, 1'b0, 1'b1, 1, 0, 8'h1C, 1'b1, 1'b0};
`ifdef PS2_PARITY_CHECK_EN
    vecs[12] = '{8'h78, 1'b1, 1'b1, 0, 1, 8'h1C, 1'b1, 1'b0};
`else
    vecs[12] = '{8'h78, 1'b1, 1'b1, 1, 0, 8'h78, 1'b0, 1'b0};
`endif
    vecs[13] = '{8'h78, 1'b0, 1'b1, 1, 0, 8'h78, 1'b0, 1'b0};
    vecs[14] = '{8'hF0, 1'b0, 1'b1, 0, 0, 8'h78, 1'b0, 1'b0};
    vecs[15] = '{8'h1E, 1'b0, 1'b0, 0, 1, 8'h78, 1'b0, 1'b0};
    vecs[16] = '{8'h2B, 1'b0, 1'b1, 1, 0, 8'h2B, 1'b1, 1'b0};

    // Reset state.
    #100;
    check("rst code", 32'(Scan_Code), 32'h0);
    check("rst valid", 32'(Scan_Valid), 32'h0);
    check("rst break", 32'(Break), 32'h0);
    check("rst ext", 32'(Extended), 32'h0);
    check("rst err", 32'(Frame_Error), 32'h0);
    RESET = 1'b1;
    #200;

    // Frame table.
    for (int i = 0; i < NV; i++) begin
      v0 = vld_cnt;
      e0 = err_cnt;
      send_frame(vecs[i].dat, vecs[i].par_bad, vecs[i].stop);
      check($sformatf("v%0d valid pulses", i), 32'(vld_cnt - v0), 32'(vecs[i].exp_vld));
      check($sformatf("v%0d error pulses", i), 32'(err_cnt - e0), 32'(vecs[i].exp_err));
      check($sformatf("v%0d code", i), 32'(Scan_Code), 32'(vecs[i].exp_code));
      check($sformatf("v%0d break", i), 32'(Break), 32'(vecs[i].exp_brk));
      check($sformatf("v%0d ext", i), 32'(Extended), 32'(vecs[i].exp_ext));
    end
    check("pulse code", 32'(pulse_code), 32'h2B);
    check("pulse break", 32'(pulse_brk), 32'h1);
    check("pulse ext", 32'(pulse_ext), 32'h0);

    // Timeout mid-frame: set break flag, stall after 4 data bits, expect abort near 200 us.
    send_frame(8'hF0, 1'b0, 1'b1);
    v0 = vld_cnt;
    e0 = err_cnt;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    #190_000;
    check("tmo early", 32'(err_cnt - e0), 32'h0);
    #60_000;
    check("tmo error", 32'(err_cnt - e0), 32'h1);
    check("tmo no valid", 32'(vld_cnt - v0), 32'h0);
    send_frame(8'h16, 1'b0, 1'b1);
    check("post tmo valid", 32'(vld_cnt - v0), 32'h1);
    check("post tmo code", 32'(Scan_Code), 32'h16);
    check("post tmo break", 32'(Break), 32'h0);

    // Short clock glitches with data low must not start a frame.
    v0 = vld_cnt;
    e0 = err_cnt;
    PS2_Data = 1'b0;
    for (int i = 0; i < 5; i++) begin
      PS2_Clock = 1'b0;
      #40;
      PS2_Clock = 1'b1;
      #500;
    end
    PS2_Data = 1'b1;
    #2000;
    send_frame(8'h4D, 1'b0, 1'b1);
    check("glitch valid", 32'(vld_cnt - v0), 32'h1);
    check("glitch err", 32'(err_cnt - e0), 32'h0);
    check("glitch code", 32'(Scan_Code), 32'h4D);

    // Reset mid-frame discards the partial byte.
    v0 = vld_cnt;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    RESET = 1'b0;
    #100;
    check("midrst code", 32'(Scan_Code), 32'h0);
    check("midrst break", 32'(Break), 32'h0);
    check("midrst valid", 32'(vld_cnt - v0), 32'h0);
    PS2_Data = 1'b1;
    #200;
    RESET = 1'b1;
    #2000;
    send_frame(8'h29, 1'b0, 1'b1);
    check("after rst valid", 32'(vld_cnt - v0), 32'h1);
    check("after rst code", 32'(Scan_Code), 32'h29);

    check("valid+error overlap", 32'(both_cnt), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
